// File: rtl/cbadc_ctrl_emulator.sv
// Control-bounded ADC front-end emulator: N cascaded saturating integrators with
// sign comparators turning a held PCM sample into one N-bit control vector per clock.
module cbadc_ctrl_emulator #(
  parameter int N          = 3,
  parameter int IN_W       = 14,
  parameter int STATE_W    = 24,
  parameter int OSR        = 12,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [IN_W-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic [N-1:0]           ctrl_out,
  output logic                   ctrl_valid,
  output logic                   frame,
  output logic                   ovf
);

  localparam int PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int SUM_W = STATE_W + 2;
  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(OSR - 1);
  localparam logic signed [SUM_W-1:0] FB      = SUM_W'(2 ** (STATE_W - 3));
  localparam logic signed [SUM_W-1:0] SMAX    = SUM_W'((2 ** (STATE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SMIN    = ~SMAX;

  logic [PH_W-1:0]           phase_q, phase_d;
  logic signed [IN_W-1:0]    hold_q, hold_d;
  logic signed [STATE_W-1:0] x_q [N];
  logic signed [STATE_W-1:0] x_d [N];
  logic signed [STATE_W-1:0] stg_in [N];
  logic signed [SUM_W-1:0]   sum [N];
  logic [N-1:0]              s_q, s_d;
  logic                      ovf_q, ovf_d;
  logic                      valid_q;
  logic                      clamp;
  logic signed [STATE_W-1:0] u_ext;

  // Input scaling puts full-scale near FB; narrow states need a right shift instead.
  if (STATE_W - 2 >= IN_W) begin : g_up
    assign u_ext = STATE_W'(hold_q) <<< (STATE_W - 2 - IN_W);
  end else begin : g_dn
    assign u_ext = STATE_W'(hold_q >>> (IN_W - STATE_W + 2));
  end

  assign sample_ready = en && (phase_q == PH_LAST);

  always_comb begin
    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    hold_d  = (sample_valid && sample_ready) ? sample_in : hold_q;
  end

  always_comb begin
    clamp     = 1'b0;
    s_d       = '0;
    stg_in[0] = u_ext;
    for (int unsigned i = 1; i < N; i++) begin
      stg_in[i] = x_q[i-1] >>> GAIN_SHIFT;
    end
    for (int unsigned i = 0; i < N; i++) begin
      sum[i] = SUM_W'(x_q[i]) + SUM_W'(stg_in[i]) - (s_q[i] ? FB : -FB);
      if (sum[i] > SMAX) begin
        x_d[i] = STATE_W'(SMAX);
        clamp  = 1'b1;
      end else if (sum[i] < SMIN) begin
        x_d[i] = STATE_W'(SMIN);
        clamp  = 1'b1;
      end else begin
        x_d[i] = STATE_W'(sum[i]);
      end
      s_d[i] = ~x_q[i][STATE_W-1];
    end
    ovf_d = ovf_q | clamp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      hold_q  <= '0;
      x_q     <= '{default: '0};
      s_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        phase_q <= phase_d;
        hold_q  <= hold_d;
        x_q     <= x_d;
        s_q     <= s_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign ctrl_out   = s_q;
  assign ctrl_valid = valid_q;
  assign frame      = valid_q && (phase_q == PH_W'(1));
  assign ovf        = ovf_q;

endmodule
